me: RTL and testbench

PIN-entry access controller: an access request opens a four-digit entry window, each strobed BCD digit is checked against a stored PIN, and exactly one verdict is issued. Accepted or denied is signalled on two mutually exclusive level outputs. The block sits between a keypad front end (digit plus strobe) and the door/lock actuator logic.

---
 rtl/me_pkg.sv | 25 ++
 rtl/me_stb_edge.sv | 22 ++
 rtl/me.sv | 73 +++++++
 tb/tb_me.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - Shared types and constants for the PIN-entry access controller.
package me_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURA  = 2'd1,
        ACEPTADO = 2'd2,
        DENEGADO = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_PIN = 16'h6969;
    localparam int          NUM_DIGITS  = 4;
    localparam logic [1:0]  LAST_DIGIT  = 2'(NUM_DIGITS - 1);

    // Digit 0 is the most-significant nibble, i.e. the first one keyed in.
    function automatic logic [3:0] pin_nibble(input logic [15:0] pin, input logic [1:0] idx);
        case (idx)
            2'd0:    return pin[15:12];
            2'd1:    return pin[11:8];
            2'd2:    return pin[7:4];
            default: return pin[3:0];
        endcase
    endfunction

endpackage

// File: rtl/me_stb_edge.sv
// rtl/me_stb_edge.sv - Rising-edge detector for the keypad digit strobe.
module me_stb_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    output logic stb_ev
);

    logic stb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= stb;
        end
    end

    // A strobe held high over several cycles yields a single event.
    assign stb_ev = stb & ~stb_q;

endmodule

// File: rtl/me.sv
// rtl/me.sv - PIN-entry access controller: four-digit capture and accept/deny verdict.
module me
    import me_pkg::*;
#(
    parameter logic [15:0] PIN = DEFAULT_PIN
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DIGITO_STB,
    input  logic       SOLICITUD_ACCESO,
    input  logic [3:0] DIGITO,
    output logic       ACCESO_ACEPTADO,
    output logic       ACCESO_DENEGADO
);

    state_t     state, state_n;
    logic [1:0] count, count_n;
    logic       mismatch, mismatch_n;
    logic       stb_ev;
    logic       miss_acc;

    me_stb_edge u_stb_edge (
        .clk    (CLK),
        .rst_n  (RESET),
        .stb    (DIGITO_STB),
        .stb_ev (stb_ev)
    );

    // Values 10..15 never equal a BCD nibble, so they fall out as mismatches.
    assign miss_acc = mismatch | (DIGITO != pin_nibble(PIN, count));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            count    <= 2'd0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            mismatch <= mismatch_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        mismatch_n = mismatch;
        if (SOLICITUD_ACCESO) begin
            // A request restarts entry; a coincident strobe is already digit 1.
            state_n = CAPTURA;
            if (stb_ev) begin
                count_n    = 2'd1;
                mismatch_n = (DIGITO != PIN[15:12]);
            end else begin
                count_n    = 2'd0;
                mismatch_n = 1'b0;
            end
        end else if (state == CAPTURA && stb_ev) begin
            if (count == LAST_DIGIT) begin
                state_n    = miss_acc ? DENEGADO : ACEPTADO;
                count_n    = 2'd0;
                mismatch_n = 1'b0;
            end else begin
                count_n    = count + 2'd1;
                mismatch_n = miss_acc;
            end
        end
    end

    assign ACCESO_ACEPTADO = (state == ACEPTADO);
    assign ACCESO_DENEGADO = (state == DENEGADO);

endmodule

// File: tb/tb_me.sv
// tb/tb_me.sv - Self-checking bench for the PIN-entry access controller.
module tb_me;

    logic       CLK;
    logic       RESET;
    logic       DIGITO_STB;
    logic       SOLICITUD_ACCESO;
    logic [3:0] DIGITO;
    logic       ACCESO_ACEPTADO;
    logic       ACCESO_DENEGADO;

    int checks = 0;
    int errors = 0;

    // Reference model: entry mode (0 idle, 1 capturing, 2 accepted, 3 denied) and keyed digits.
    int         m_mode;
    int         m_digits[$];
    logic       m_stb_q;
    logic [15:0] pin_v;

    me dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DIGITO_STB       (DIGITO_STB),
        .SOLICITUD_ACCESO (SOLICITUD_ACCESO),
        .DIGITO           (DIGITO),
        .ACCESO_ACEPTADO  (ACCESO_ACEPTADO),
        .ACCESO_DENEGADO  (ACCESO_DENEGADO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [3:0] pin_digit(input int idx);
        logic [15:0] p;
        p = pin_v >> (12 - 4 * idx);
        return p[3:0];
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_stb_q = 1'b0;
        m_digits.delete();
    endfunction

    function automatic void model_edge(input logic req, input logic stb, input logic [3:0] dig);
        logic ev;
        logic ok;
        ev      = stb & ~m_stb_q;
        m_stb_q = stb;
        if (req) begin
            m_mode = 1;
            m_digits.delete();
            if (ev) m_digits.push_back(int'(dig));
        end else if (m_mode == 1 && ev) begin
            m_digits.push_back(int'(dig));
            if (m_digits.size() == 4) begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (m_digits[i] != int'(pin_digit(i))) ok = 1'b0;
                m_mode = ok ? 2 : 3;
                m_digits.delete();
            end
        end
    endfunction

    function automatic logic [1:0] model_out();
        return {m_mode == 2, m_mode == 3};
    endfunction

    task automatic step(input logic req, input logic stb, input logic [3:0] dig, input logic rst_n);
        @(negedge CLK);
        SOLICITUD_ACCESO = req;
        DIGITO_STB       = stb;
        DIGITO           = dig;
        RESET            = rst_n;
        if (!rst_n) model_reset();
        @(posedge CLK);
        if (rst_n) model_edge(req, stb, dig);
        #1;
    endtask

    task automatic pulse(input logic [3:0] dig);
        step(1'b0, 1'b1, dig, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_reset();
        RESET = 1'b0; DIGITO_STB = 1'b0; SOLICITUD_ACCESO = 1'b0; DIGITO = 4'd0;
        model_reset();
        #1;
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL reset_state: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        step(1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL reset_release: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
    endtask

    task automatic test_early_request();
        step(1'b1, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 4'd6, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        pulse(4'd9);
        pulse(4'd6);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL early_3rd_digit: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        step(1'b0, 1'b1, 4'd9, 1'b1);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b10) begin
            errors++; $display("FAIL early_accept_edge: got %b%b want 10", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 4'd9, 1'b1);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b10) begin
            errors++; $display("FAIL early_accept_hold: got %b%b want 10", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
    endtask

    task automatic test_wrong_first();
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 4'd3, 1'b1);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL first_clear_on_req: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        pulse(4'd9);
        pulse(4'd6);
        step(1'b0, 1'b1, 4'd9, 1'b1);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b01) begin
            errors++; $display("FAIL first_deny: got %b%b want 01", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
    endtask

    task automatic test_wrong_middle();
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 1'b1);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL middle_clear_on_req: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        pulse(4'd6);
        pulse(4'd3);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL middle_no_early_deny: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        pulse(4'd6);
        pulse(4'd9);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b01) begin
            errors++; $display("FAIL middle_deny: got %b%b want 01", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
    endtask

    task automatic test_recovery();
        step(1'b1, 1'b1, 4'd6, 1'b1);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL recover_clear_on_req: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        pulse(4'd9);
        pulse(4'd6);
        pulse(4'd9);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b10) begin
            errors++; $display("FAIL recover_accept: got %b%b want 10", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
    endtask

    task automatic test_reset_mid_entry();
        step(1'b1, 1'b1, 4'd6, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        @(negedge CLK);
        RESET = 1'b0; DIGITO_STB = 1'b1; DIGITO = 4'd9; SOLICITUD_ACCESO = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL midreset_immediate: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        @(posedge CLK);
        #1;
        step(1'b0, 1'b0, 4'd0, 1'b1);
        pulse(4'd6);
        pulse(4'd3);
        pulse(4'd9);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL midreset_ignored: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
    endtask

    task automatic test_strobe_rules();
        pulse(4'd6);
        pulse(4'd9);
        pulse(4'd6);
        pulse(4'd9);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL idle_strobes_ignored: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        step(1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd6, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        pulse(4'd9);
        pulse(4'd6);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b00) begin
            errors++; $display("FAIL long_strobe_once: got %b%b want 00", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        pulse(4'd9);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b10) begin
            errors++; $display("FAIL long_strobe_accept: got %b%b want 10", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
        pulse(4'd15);
        checks++;
        if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== 2'b10) begin
            errors++; $display("FAIL verdict_holds: got %b%b want 10", ACCESO_ACEPTADO, ACCESO_DENEGADO);
        end
    endtask

    task automatic test_random();
        logic       req, stb, rst_n;
        logic [3:0] dig;
        int         idx;
        for (int n = 0; n < 3000; n++) begin
            req   = ($urandom_range(0, 24) == 0);
            stb   = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 299) != 0);
            idx   = (m_digits.size() < 4) ? m_digits.size() : 0;
            dig   = ($urandom_range(0, 5) != 0) ? pin_digit(idx) : 4'($urandom_range(0, 15));
            step(req, stb, dig, rst_n);
            checks++;
            if ({ACCESO_ACEPTADO, ACCESO_DENEGADO} !== model_out()) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %b%b want %b", n, ACCESO_ACEPTADO, ACCESO_DENEGADO, model_out());
            end
        end
    endtask

    initial begin
        pin_v = 16'h6969;
        test_reset();
        test_early_request();
        test_wrong_first();
        test_wrong_middle();
        test_recovery();
        test_reset_mid_entry();
        test_strobe_rules();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
